pipe_hazard_ctrl: RTL and testbench

- Parametrised hazard, forwarding and flush controller for the RISC-V pipeline.
- Generalises load-use stall plus fixed two-source forwarding to:
  - N forwarding stages, with nearest-stage priority.
  - A register scoreboard for multi-cycle (long-latency) units such as mul/div and variable-latency loads.
- Sits beside the ID/EX boundary; drives PC/IF_ID stall, ID_EX bubble, flushes and the ALU operand mux selects.

---
 rtl/pipe_hazard_ctrl.sv | 131 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and flush control for the ID/EX boundary, with a register scoreboard for long-latency units.
// Optional PIPE_HAZARD_PERF_EN adds saturating stall/flush/scoreboard-stall event counters.
module pipe_hazard_ctrl #(
  parameter int RF_ADDRESS = 5,
  parameter int NUM_FWD    = 2,
  parameter int MAX_OUT    = 4,
  localparam int FWD_SEL_W = $clog2(NUM_FWD + 1)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         id_valid,
  input  logic [RF_ADDRESS-1:0]        id_rs1,
  input  logic [RF_ADDRESS-1:0]        id_rs2,
  input  logic                         id_rs1_used,
  input  logic                         id_rs2_used,
  input  logic [RF_ADDRESS-1:0]        id_rd,
  input  logic                         id_reg_write,
  input  logic                         id_long_lat,
  input  logic [RF_ADDRESS-1:0]        ex_rd,
  input  logic                         ex_mem_read,
  input  logic                         ex_redirect,
  input  logic [RF_ADDRESS-1:0]        ex_rs1,
  input  logic [RF_ADDRESS-1:0]        ex_rs2,
  input  logic [NUM_FWD*RF_ADDRESS-1:0] fwd_rd,
  input  logic [NUM_FWD-1:0]           fwd_reg_write,
  input  logic                         lat_done_valid,
  input  logic [RF_ADDRESS-1:0]        lat_done_rd,
  output logic                         stall,
  output logic                         bubble_ex,
  output logic                         flush_if_id,
  output logic                         flush_id_ex,
  output logic [FWD_SEL_W-1:0]         fwd_a_sel,
  output logic [FWD_SEL_W-1:0]         fwd_b_sel,
  output logic [2**RF_ADDRESS-1:0]     sb_pending,
  output logic                         sb_full
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [31:0]                  perf_stall_cnt,
  output logic [31:0]                  perf_flush_cnt,
  output logic [31:0]                  perf_sb_stall_cnt
`endif
);

  localparam int NREG  = 2**RF_ADDRESS;
  localparam int CNT_W = $clog2(MAX_OUT + 1);

  logic [NREG-1:0]  pending_q, pending_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full;
  logic             luh, sbh, raw, waw, structural;
  logic             issue, complete;

  assign full = (count_q == CNT_W'(MAX_OUT));

  assign luh = id_valid && ex_mem_read && (ex_rd != '0) &&
               ((id_rs1_used && (id_rs1 == ex_rd)) || (id_rs2_used && (id_rs2 == ex_rd)));

  // Pending bits come straight from the register, so a completion only frees dependants next cycle.
  assign raw        = (id_rs1_used && pending_q[id_rs1]) || (id_rs2_used && pending_q[id_rs2]);
  assign waw        = id_reg_write && (id_rd != '0) && pending_q[id_rd];
  assign structural = id_long_lat && full;
  assign sbh        = id_valid && (raw || waw || structural);

  assign stall       = !reset && (luh || sbh) && !ex_redirect;
  assign bubble_ex   = stall;
  assign flush_if_id = reset || ex_redirect;
  assign flush_id_ex = reset || ex_redirect;
  assign sb_full     = !reset && full;
  assign sb_pending  = pending_q;

  assign issue    = !reset && id_valid && !stall && !ex_redirect && id_long_lat &&
                    id_reg_write && (id_rd != '0);
  assign complete = lat_done_valid && (lat_done_rd != '0) && pending_q[lat_done_rd];

  always_comb begin
    pending_d = pending_q;
    if (complete) pending_d[lat_done_rd] = 1'b0;
    if (issue)    pending_d[id_rd]       = 1'b1;
  end

  always_comb begin
    count_d = count_q;
    case ({issue, complete})
      2'b10:   if (count_q < CNT_W'(MAX_OUT)) count_d = count_q + 1'b1;
      2'b01:   if (count_q != '0)             count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
      count_q   <= '0;
    end else begin
      pending_q <= pending_d;
      count_q   <= count_d;
    end
  end

  // Scan oldest to nearest so the nearest matching source wins.
  always_comb begin
    fwd_a_sel = '0;
    fwd_b_sel = '0;
    if (!reset) begin
      for (int k = NUM_FWD - 1; k >= 0; k--) begin
        if (fwd_reg_write[k] && (fwd_rd[k*RF_ADDRESS +: RF_ADDRESS] == ex_rs1) && (ex_rs1 != '0))
          fwd_a_sel = FWD_SEL_W'(k + 1);
        if (fwd_reg_write[k] && (fwd_rd[k*RF_ADDRESS +: RF_ADDRESS] == ex_rs2) && (ex_rs2 != '0))
          fwd_b_sel = FWD_SEL_W'(k + 1);
      end
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cnt    <= '0;
      perf_flush_cnt    <= '0;
      perf_sb_stall_cnt <= '0;
    end else begin
      if (stall && (perf_stall_cnt != 32'hFFFF_FFFF))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (ex_redirect && (perf_flush_cnt != 32'hFFFF_FFFF))
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
      if (stall && sbh && (perf_sb_stall_cnt != 32'hFFFF_FFFF))
        perf_sb_stall_cnt <= perf_sb_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with default parameters (RF_ADDRESS=5, NUM_FWD=2, MAX_OUT=4).
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_rs1_used, id_rs2_used, id_reg_write, id_long_lat;
  logic [4:0]  ex_rd, ex_rs1, ex_rs2;
  logic        ex_mem_read, ex_redirect;
  logic [9:0]  fwd_rd;
  logic [1:0]  fwd_reg_write;
  logic        lat_done_valid;
  logic [4:0]  lat_done_rd;
  logic        stall, bubble_ex, flush_if_id, flush_id_ex;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic [31:0] sb_pending;
  logic        sb_full;
`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt, perf_sb_stall_cnt;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_reg_write(id_reg_write), .id_long_lat(id_long_lat),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_redirect(ex_redirect),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .fwd_rd(fwd_rd), .fwd_reg_write(fwd_reg_write),
    .lat_done_valid(lat_done_valid), .lat_done_rd(lat_done_rd),
    .stall(stall), .bubble_ex(bubble_ex),
    .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .sb_pending(sb_pending), .sb_full(sb_full)
`ifdef PIPE_HAZARD_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt),
    .perf_sb_stall_cnt(perf_sb_stall_cnt)
`endif
  );

  task automatic idle();
    id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rs1_used = 0; id_rs2_used = 0;
    id_rd = 0; id_reg_write = 0; id_long_lat = 0;
    ex_rd = 0; ex_mem_read = 0; ex_redirect = 0; ex_rs1 = 0; ex_rs2 = 0;
    fwd_rd = 0; fwd_reg_write = 0; lat_done_valid = 0; lat_done_rd = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic issue_long(input logic [4:0] rd);
    idle();
    id_valid = 1; id_long_lat = 1; id_reg_write = 1; id_rd = rd;
    step();
    idle();
  endtask

  task automatic test_reset();
    idle();
    reset = 1;
    // hazard and forwarding stimulus present while reset is held
    id_valid = 1; ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_rs1_used = 1;
    ex_rs1 = 3; fwd_rd = {5'd3, 5'd3}; fwd_reg_write = 2'b11;
    #1;
    vectors++;
    if (stall !== 1'b0 || bubble_ex !== 1'b0) begin
      miscompares++; $display("FAIL reset_stall: stall=%b bubble=%b, want 0 0", stall, bubble_ex);
    end
    vectors++;
    if (flush_if_id !== 1'b1 || flush_id_ex !== 1'b1) begin
      miscompares++; $display("FAIL reset_flush: if_id=%b id_ex=%b, want 1 1", flush_if_id, flush_id_ex);
    end
    vectors++;
    if (fwd_a_sel !== 2'd0 || sb_full !== 1'b0) begin
      miscompares++; $display("FAIL reset_fwd_full: fwd_a=%0d sb_full=%b, want 0 0", fwd_a_sel, sb_full);
    end
    step(); step();
    idle();
    reset = 0;
    #1;
    vectors++;
    if (sb_pending !== 32'h0 || flush_if_id !== 1'b0) begin
      miscompares++; $display("FAIL reset_release: pending=%h flush=%b, want 0 0", sb_pending, flush_if_id);
    end
  endtask

  task automatic test_load_use();
    idle();
    id_valid = 1; ex_mem_read = 1; ex_rd = 5; id_rs2 = 5; id_rs2_used = 1;
    #1;
    vectors++;
    if (stall !== 1'b1 || bubble_ex !== 1'b1 || flush_id_ex !== 1'b0) begin
      miscompares++; $display("FAIL lu_rs2: stall=%b bubble=%b flush=%b, want 1 1 0", stall, bubble_ex, flush_id_ex);
    end
    id_rs2_used = 0; #1;
    vectors++;
    if (stall !== 1'b0) begin
      miscompares++; $display("FAIL lu_unused: stall=%b, want 0", stall);
    end
    id_rs1 = 5; id_rs1_used = 1; #1;
    vectors++;
    if (stall !== 1'b1) begin
      miscompares++; $display("FAIL lu_rs1: stall=%b, want 1", stall);
    end
    ex_rd = 0; id_rs1 = 0; #1;
    vectors++;
    if (stall !== 1'b0) begin
      miscompares++; $display("FAIL lu_x0: stall=%b, want 0", stall);
    end
    ex_rd = 5; id_rs1 = 5; ex_mem_read = 0; #1;
    vectors++;
    if (stall !== 1'b0) begin
      miscompares++; $display("FAIL lu_noload: stall=%b, want 0", stall);
    end
    idle(); #1;
  endtask

  task automatic test_forward();
    idle();
    fwd_rd = {5'd3, 5'd3}; fwd_reg_write = 2'b11; ex_rs1 = 3; ex_rs2 = 3;
    #1;
    vectors++;
    if (fwd_a_sel !== 2'd1 || fwd_b_sel !== 2'd1) begin
      miscompares++; $display("FAIL fwd_nearest: a=%0d b=%0d, want 1 1", fwd_a_sel, fwd_b_sel);
    end
    fwd_reg_write = 2'b10; #1;
    vectors++;
    if (fwd_a_sel !== 2'd2) begin
      miscompares++; $display("FAIL fwd_older: a=%0d, want 2", fwd_a_sel);
    end
    ex_rs1 = 0; fwd_rd = {5'd0, 5'd0}; fwd_reg_write = 2'b11; #1;
    vectors++;
    if (fwd_a_sel !== 2'd0 || fwd_b_sel !== 2'd0) begin
      miscompares++; $display("FAIL fwd_x0: a=%0d b=%0d, want 0 0", fwd_a_sel, fwd_b_sel);
    end
    fwd_rd = {5'd9, 5'd4}; ex_rs1 = 9; ex_rs2 = 4; #1;
    vectors++;
    if (fwd_a_sel !== 2'd2 || fwd_b_sel !== 2'd1) begin
      miscompares++; $display("FAIL fwd_split: a=%0d b=%0d, want 2 1", fwd_a_sel, fwd_b_sel);
    end
    idle(); #1;
  endtask

  task automatic test_scoreboard_raw();
    issue_long(7);
    vectors++;
    if (sb_pending !== 32'h80) begin
      miscompares++; $display("FAIL sb_set7: pending=%h, want 00000080", sb_pending);
    end
    id_valid = 1; id_rs1 = 7; id_rs1_used = 1; #1;
    vectors++;
    if (stall !== 1'b1) begin
      miscompares++; $display("FAIL sb_raw: stall=%b, want 1", stall);
    end
    id_rs1_used = 0; id_reg_write = 1; id_rd = 7; #1;
    vectors++;
    if (stall !== 1'b1) begin
      miscompares++; $display("FAIL sb_waw: stall=%b, want 1", stall);
    end
    id_reg_write = 0; id_rd = 0; id_rs1_used = 1;
    lat_done_valid = 1; lat_done_rd = 7; #1;
    vectors++;
    if (stall !== 1'b1) begin
      miscompares++; $display("FAIL sb_done_same: stall=%b, want 1", stall);
    end
    step();
    lat_done_valid = 0; #1;
    vectors++;
    if (stall !== 1'b0 || sb_pending !== 32'h0) begin
      miscompares++; $display("FAIL sb_release: stall=%b pending=%h, want 0 0", stall, sb_pending);
    end
    idle(); #1;
  endtask

  task automatic test_full();
    issue_long(1); issue_long(2); issue_long(3);
    vectors++;
    if (sb_full !== 1'b0 || sb_pending !== 32'h0000000E) begin
      miscompares++; $display("FAIL full_three: full=%b pending=%h, want 0 0000000e", sb_full, sb_pending);
    end
    // issue x4 while x1 completes: count holds at 3
    id_valid = 1; id_long_lat = 1; id_reg_write = 1; id_rd = 4;
    lat_done_valid = 1; lat_done_rd = 1;
    step(); idle(); #1;
    vectors++;
    if (sb_full !== 1'b0 || sb_pending !== 32'h0000001C) begin
      miscompares++; $display("FAIL full_swap: full=%b pending=%h, want 0 0000001c", sb_full, sb_pending);
    end
    issue_long(1);
    vectors++;
    if (sb_full !== 1'b1 || sb_pending !== 32'h0000001E) begin
      miscompares++; $display("FAIL full_four: full=%b pending=%h, want 1 0000001e", sb_full, sb_pending);
    end
    id_valid = 1; id_long_lat = 1; id_reg_write = 1; id_rd = 9; #1;
    vectors++;
    if (stall !== 1'b1) begin
      miscompares++; $display("FAIL full_struct: stall=%b, want 1", stall);
    end
    lat_done_valid = 1; lat_done_rd = 2; #1;
    vectors++;
    if (stall !== 1'b1) begin
      miscompares++; $display("FAIL full_done_same: stall=%b, want 1", stall);
    end
    step();
    lat_done_valid = 0; #1;
    vectors++;
    if (stall !== 1'b0 || sb_full !== 1'b0) begin
      miscompares++; $display("FAIL full_release: stall=%b full=%b, want 0 0", stall, sb_full);
    end
    step(); idle(); #1;
    vectors++;
    if (sb_full !== 1'b1 || sb_pending !== 32'h0000021A) begin
      miscompares++; $display("FAIL full_refill: full=%b pending=%h, want 1 0000021a", sb_full, sb_pending);
    end
    // completion for a non-pending register leaves the count alone
    lat_done_valid = 1; lat_done_rd = 20;
    step(); idle(); #1;
    vectors++;
    if (sb_full !== 1'b1 || sb_pending !== 32'h0000021A) begin
      miscompares++; $display("FAIL full_spurious: full=%b pending=%h, want 1 0000021a", sb_full, sb_pending);
    end
  endtask

  task automatic test_redirect();
    idle();
    id_valid = 1; ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_rs1_used = 1;
    id_long_lat = 1; id_reg_write = 1; id_rd = 12; ex_redirect = 1;
    #1;
    vectors++;
    if (stall !== 1'b0 || bubble_ex !== 1'b0 || flush_if_id !== 1'b1 || flush_id_ex !== 1'b1) begin
      miscompares++;
      $display("FAIL redir_over_stall: stall=%b bubble=%b fif=%b fie=%b, want 0 0 1 1",
               stall, bubble_ex, flush_if_id, flush_id_ex);
    end
    step(); idle(); #1;
    vectors++;
    if (sb_pending !== 32'h0000021A || sb_full !== 1'b1) begin
      miscompares++; $display("FAIL redir_no_issue: pending=%h full=%b, want 0000021a 1", sb_pending, sb_full);
    end
  endtask

  task automatic test_reset_mid();
    reset = 1;
    step();
    reset = 0; #1;
    vectors++;
    if (sb_pending !== 32'h0 || sb_full !== 1'b0) begin
      miscompares++; $display("FAIL mid_reset: pending=%h full=%b, want 0 0", sb_pending, sb_full);
    end
    lat_done_valid = 1; lat_done_rd = 1;
    step(); idle(); #1;
    vectors++;
    if (sb_pending !== 32'h0) begin
      miscompares++; $display("FAIL mid_late_done: pending=%h, want 0", sb_pending);
    end
    // a count that stayed at zero fills exactly on the fourth issue
    issue_long(1); issue_long(2); issue_long(3);
    vectors++;
    if (sb_full !== 1'b0) begin
      miscompares++; $display("FAIL mid_count3: full=%b, want 0", sb_full);
    end
    issue_long(4);
    vectors++;
    if (sb_full !== 1'b1) begin
      miscompares++; $display("FAIL mid_count4: full=%b, want 1", sb_full);
    end
  endtask

  initial begin
    idle();
    reset = 1;
    test_reset();
    test_load_use();
    test_forward();
    test_scoreboard_raw();
    test_full();
    test_redirect();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
